// File: rtl/video_timing_pkg.sv
// video_timing_pkg -- shared types and helpers for the video timing engine.
//   timing_t      : one complete timing set (totals, sync, back porch,
//                   active, sync polarities) for both axes.
//   timing_legal  : returns 1 when a timing set can be displayed safely.
// Field width VT_W matches the engine's default counter width.
package video_timing_pkg;

  localparam int VT_W = 14;

  typedef struct packed {
    logic [VT_W-1:0] h_total;
    logic [VT_W-1:0] h_sync;
    logic [VT_W-1:0] h_bp;
    logic [VT_W-1:0] h_active;
    logic [VT_W-1:0] v_total;
    logic [VT_W-1:0] v_sync;
    logic [VT_W-1:0] v_bp;
    logic [VT_W-1:0] v_active;
    logic            hsync_pol;
    logic            vsync_pol;
  } timing_t;

  // Sums are widened by two bits so sync+bp+active cannot wrap around.
  function automatic logic timing_legal(input timing_t t);
    logic [VT_W+1:0] h_used;
    logic [VT_W+1:0] v_used;
    h_used = {2'b00, t.h_sync} + {2'b00, t.h_bp} + {2'b00, t.h_active};
    v_used = {2'b00, t.v_sync} + {2'b00, t.v_bp} + {2'b00, t.v_active};
    return (h_used <= {2'b00, t.h_total}) && (v_used <= {2'b00, t.v_total}) &&
           (t.h_total >= VT_W'(2)) && (t.v_total >= VT_W'(2)) &&
           (t.h_sync != '0) && (t.h_active != '0) &&
           (t.v_sync != '0) && (t.v_active != '0);
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// video_timing_axis -- position counter and region decode for one axis.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   advance             : step the counter (wraps to 0 after total-1)
//   load, load_val      : preload the counter (has priority over advance)
//   total, sync_len, bp, active : current timing for this axis
//   pos                 : registered position
//   at_last             : pos is the last position of the axis
//   in_sync, visible    : region decode of pos
//   offset              : pos relative to the first visible position
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] total,
  input  logic [CNT_W-1:0] sync_len,
  input  logic [CNT_W-1:0] bp,
  input  logic [CNT_W-1:0] active,
  output logic [CNT_W-1:0] pos,
  output logic [CNT_W-1:0] offset,
  output logic             at_last,
  output logic             in_sync,
  output logic             visible
);

  logic [CNT_W-1:0] vis_start;
  logic [CNT_W-1:0] vis_end;

  // Region decode; >= on the wrap test keeps an out-of-range position from running away.
  always_comb begin
    vis_start = sync_len + bp;
    vis_end   = vis_start + active;
    at_last   = (pos >= (total - CNT_W'(1)));
    in_sync   = (pos < sync_len);
    visible   = (pos >= vis_start) && (pos < vis_end);
    offset    = pos - vis_start;
  end

  // Position counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos <= '0;
    end else if (load) begin
      pos <= load_val;
    end else if (advance) begin
      pos <= at_last ? '0 : (pos + CNT_W'(1));
    end else begin
      pos <= pos;
    end
  end

endmodule

// File: rtl/video_timing_engine.sv
// video_timing_engine -- programmable raster timing generator.
// Ports:
//   pixel_clock, reset_n          : clock, synchronous active-low reset
//   cfg_* / cfg_valid             : requested timing and its strobe
//   cfg_ack / cfg_err             : commit pulse / reject pulse
//   cfg_pending                   : legal request waiting for the frame wrap
//   enable                        : run (1) / hold (0)
//   ext_sync                      : asynchronous genlock input
//   timing_h_pos, timing_v_pos    : raster position
//   pixel_x, pixel_y              : position inside the visible area
//   video_hsync/vsync/den         : sync and data-enable outputs
//   video_line_start/frame_start  : line / frame markers
//   frame_count                   : frames completed (mod 2^16)
// All outputs are registered and lag the internal counters by one cycle.
// Optional feature: define VIDEO_TIMING_ENGINE_GENLOCK_EN to let a rising
// edge on ext_sync preload the counters; otherwise ext_sync is ignored.
module video_timing_engine
  import video_timing_pkg::*;
#(
  parameter int CNT_W         = 14,
  parameter int DEF_H_TOTAL   = 2200,
  parameter int DEF_H_SYNC    = 44,
  parameter int DEF_H_BP      = 148,
  parameter int DEF_H_ACTIVE  = 1920,
  parameter bit DEF_HSYNC_POL = 1'b1,
  parameter int DEF_V_TOTAL   = 1125,
  parameter int DEF_V_SYNC    = 5,
  parameter int DEF_V_BP      = 36,
  parameter int DEF_V_ACTIVE  = 1080,
  parameter bit DEF_VSYNC_POL = 1'b1,
  parameter int SYNC_H_POS    = 1079,
  parameter int SYNC_V_POS    = 132
) (
  input  logic             pixel_clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] cfg_h_total,
  input  logic [CNT_W-1:0] cfg_h_sync,
  input  logic [CNT_W-1:0] cfg_h_bp,
  input  logic [CNT_W-1:0] cfg_h_active,
  input  logic [CNT_W-1:0] cfg_v_total,
  input  logic [CNT_W-1:0] cfg_v_sync,
  input  logic [CNT_W-1:0] cfg_v_bp,
  input  logic [CNT_W-1:0] cfg_v_active,
  input  logic             cfg_hsync_pol,
  input  logic             cfg_vsync_pol,
  input  logic             cfg_valid,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             cfg_pending,
  input  logic             enable,
  input  logic             ext_sync,
  output logic [CNT_W-1:0] timing_h_pos,
  output logic [CNT_W-1:0] timing_v_pos,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_hsync,
  output logic             video_vsync,
  output logic             video_den,
  output logic             video_line_start,
  output logic             video_frame_start,
  output logic [15:0]      frame_count
);

  localparam timing_t DEF_TIMING = '{
    h_total: VT_W'(DEF_H_TOTAL), h_sync: VT_W'(DEF_H_SYNC),
    h_bp: VT_W'(DEF_H_BP), h_active: VT_W'(DEF_H_ACTIVE),
    v_total: VT_W'(DEF_V_TOTAL), v_sync: VT_W'(DEF_V_SYNC),
    v_bp: VT_W'(DEF_V_BP), v_active: VT_W'(DEF_V_ACTIVE),
    hsync_pol: DEF_HSYNC_POL, vsync_pol: DEF_VSYNC_POL};
  localparam logic [CNT_W-1:0] SYNC_H = CNT_W'(SYNC_H_POS);
  localparam logic [CNT_W-1:0] SYNC_V = CNT_W'(SYNC_V_POS);

  timing_t          active_cfg, shadow_cfg, req_cfg;
  logic             req_ok, genlock_load, wrap, frame_adv, commit;
  logic [CNT_W-1:0] h_pos, v_pos, h_off, v_off, h_preload, v_preload;
  logic             h_last, v_last, h_in_sync, v_in_sync, h_vis, v_vis;
  logic [15:0]      frame_cnt;

  // Incoming request, its legality and the frame-wrap / commit decisions.
  always_comb begin
    req_cfg   = '{h_total: VT_W'(cfg_h_total), h_sync: VT_W'(cfg_h_sync),
                  h_bp: VT_W'(cfg_h_bp), h_active: VT_W'(cfg_h_active),
                  v_total: VT_W'(cfg_v_total), v_sync: VT_W'(cfg_v_sync),
                  v_bp: VT_W'(cfg_v_bp), v_active: VT_W'(cfg_v_active),
                  hsync_pol: cfg_hsync_pol, vsync_pol: cfg_vsync_pol};
    req_ok    = timing_legal(req_cfg);
    // A preload outside the current raster would strand the counter, so it falls back to 0.
    h_preload = (SYNC_H >= CNT_W'(active_cfg.h_total)) ? '0 : SYNC_H;
    v_preload = (SYNC_V >= CNT_W'(active_cfg.v_total)) ? '0 : SYNC_V;
    wrap      = enable & h_last & v_last;
    // A genlock preload replaces the wrap, so the commit waits for the next frame.
    frame_adv = wrap & ~genlock_load;
    commit    = frame_adv & cfg_pending;
  end

`ifdef VIDEO_TIMING_ENGINE_GENLOCK_EN
  logic [2:0] ext_sync_sr;

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      ext_sync_sr <= 3'b000;
    end else begin
      ext_sync_sr <= {ext_sync_sr[1:0], ext_sync};
    end
  end

  assign genlock_load = ext_sync_sr[1] & ~ext_sync_sr[2];
`else
  logic unused_ext_sync;
  assign unused_ext_sync = ext_sync;
  assign genlock_load    = 1'b0;
`endif

  video_timing_axis #(.CNT_W(CNT_W)) u_h_axis (
    .clk(pixel_clock), .reset_n(reset_n), .advance(enable),
    .load(genlock_load), .load_val(h_preload),
    .total(CNT_W'(active_cfg.h_total)), .sync_len(CNT_W'(active_cfg.h_sync)),
    .bp(CNT_W'(active_cfg.h_bp)), .active(CNT_W'(active_cfg.h_active)),
    .pos(h_pos), .offset(h_off), .at_last(h_last),
    .in_sync(h_in_sync), .visible(h_vis)
  );

  video_timing_axis #(.CNT_W(CNT_W)) u_v_axis (
    .clk(pixel_clock), .reset_n(reset_n), .advance(enable & h_last),
    .load(genlock_load), .load_val(v_preload),
    .total(CNT_W'(active_cfg.v_total)), .sync_len(CNT_W'(active_cfg.v_sync)),
    .bp(CNT_W'(active_cfg.v_bp)), .active(CNT_W'(active_cfg.v_active)),
    .pos(v_pos), .offset(v_off), .at_last(v_last),
    .in_sync(v_in_sync), .visible(v_vis)
  );

  // Configuration handshake: commit first, then a same-cycle request refills the shadow.
  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      active_cfg  <= DEF_TIMING;
      shadow_cfg  <= '0;
      cfg_pending <= 1'b0;
      cfg_ack     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_ack <= commit;
      cfg_err <= cfg_valid & ~req_ok;
      if (commit) begin
        active_cfg <= shadow_cfg;
      end else begin
        active_cfg <= active_cfg;
      end
      if (cfg_valid && req_ok) begin
        shadow_cfg  <= req_cfg;
        cfg_pending <= 1'b1;
      end else if (commit) begin
        shadow_cfg  <= shadow_cfg;
        cfg_pending <= 1'b0;
      end else begin
        shadow_cfg  <= shadow_cfg;
        cfg_pending <= cfg_pending;
      end
    end
  end

  // Frame counter, stepped on every natural wrap to v_pos 0.
  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      frame_cnt <= 16'd0;
    end else if (frame_adv) begin
      frame_cnt <= frame_cnt + 16'd1;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end

  // Output register stage; while held, markers are forced off and syncs inactive.
  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      timing_h_pos      <= '0;
      timing_v_pos      <= '0;
      pixel_x           <= '0;
      pixel_y           <= '0;
      video_hsync       <= ~DEF_HSYNC_POL;
      video_vsync       <= ~DEF_VSYNC_POL;
      video_den         <= 1'b0;
      video_line_start  <= 1'b0;
      video_frame_start <= 1'b0;
      frame_count       <= 16'd0;
    end else begin
      timing_h_pos <= h_pos;
      timing_v_pos <= v_pos;
      frame_count  <= frame_cnt;
      pixel_y      <= v_vis ? v_off : '0;
      if (enable) begin
        pixel_x           <= (h_vis && v_vis) ? h_off : '0;
        video_hsync       <= h_in_sync ^ ~active_cfg.hsync_pol;
        video_vsync       <= v_in_sync ^ ~active_cfg.vsync_pol;
        video_den         <= h_vis & v_vis;
        video_line_start  <= (h_pos == '0) & v_vis;
        video_frame_start <= (h_pos == '0) & (v_pos == '0);
      end else begin
        pixel_x           <= '0;
        video_hsync       <= ~active_cfg.hsync_pol;
        video_vsync       <= ~active_cfg.vsync_pol;
        video_den         <= 1'b0;
        video_line_start  <= 1'b0;
        video_frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_engine.sv
// tb_video_timing_engine -- directed self-checking bench for video_timing_engine.
// Uses a small raster: h 10/2/2/4, v 6/1/1/3, both polarities active-high,
// genlock preload 3/1. "cyc" counts rising edges since reset release; the
// registered outputs after edge cyc show counter position cyc-1.
module tb_video_timing_engine;

  localparam int W = 14;

  logic         pixel_clock = 1'b0;
  logic         reset_n, enable, ext_sync, cfg_valid;
  logic [W-1:0] cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_active;
  logic [W-1:0] cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_active;
  logic         cfg_hsync_pol, cfg_vsync_pol;
  logic         cfg_ack, cfg_err, cfg_pending;
  logic [W-1:0] timing_h_pos, timing_v_pos, pixel_x, pixel_y;
  logic         video_hsync, video_vsync, video_den, video_line_start, video_frame_start;
  logic [15:0]  frame_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  video_timing_engine #(
    .CNT_W(W),
    .DEF_H_TOTAL(10), .DEF_H_SYNC(2), .DEF_H_BP(2), .DEF_H_ACTIVE(4), .DEF_HSYNC_POL(1'b1),
    .DEF_V_TOTAL(6), .DEF_V_SYNC(1), .DEF_V_BP(1), .DEF_V_ACTIVE(3), .DEF_VSYNC_POL(1'b1),
    .SYNC_H_POS(3), .SYNC_V_POS(1)
  ) dut (
    .pixel_clock(pixel_clock), .reset_n(reset_n),
    .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_h_active(cfg_h_active), .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync),
    .cfg_v_bp(cfg_v_bp), .cfg_v_active(cfg_v_active),
    .cfg_hsync_pol(cfg_hsync_pol), .cfg_vsync_pol(cfg_vsync_pol),
    .cfg_valid(cfg_valid), .cfg_ack(cfg_ack), .cfg_err(cfg_err), .cfg_pending(cfg_pending),
    .enable(enable), .ext_sync(ext_sync),
    .timing_h_pos(timing_h_pos), .timing_v_pos(timing_v_pos),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_hsync(video_hsync), .video_vsync(video_vsync), .video_den(video_den),
    .video_line_start(video_line_start), .video_frame_start(video_frame_start),
    .frame_count(frame_count)
  );

  always #5 pixel_clock = ~pixel_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
    cyc++;
  endtask

  task automatic set_cfg(input int h_total, input int h_active);
    cfg_h_total   = W'(h_total);
    cfg_h_sync    = W'(2);
    cfg_h_bp      = W'(2);
    cfg_h_active  = W'(h_active);
    cfg_v_total   = W'(6);
    cfg_v_sync    = W'(1);
    cfg_v_bp      = W'(1);
    cfg_v_active  = W'(3);
    cfg_hsync_pol = 1'b1;
    cfg_vsync_pol = 1'b1;
  endtask

  task automatic wait_ack(input string tag, input int exp_cyc);
    for (int k = 0; k < 100 && !cfg_ack; k++) tick();
    check(tag, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    int first_den, n_den, n_ls, n_hs, n_vs, n_fs;
    first_den = 0; n_den = 0; n_ls = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    reset_n = 1'b0; enable = 1'b1; ext_sync = 1'b0; cfg_valid = 1'b0;
    set_cfg(10, 4);
    tick(); tick();
    check("rst_h_pos", 32'(timing_h_pos), 0);
    check("rst_hsync", 32'(video_hsync), 0);
    check("rst_vsync", 32'(video_vsync), 0);
    check("rst_den", 32'(video_den), 0);
    check("rst_pending", 32'(cfg_pending), 0);
    check("rst_frame_count", 32'(frame_count), 0);

    // One full default frame after reset release.
    reset_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 61; k++) begin
      tick();
      if (cyc == 1) begin
        check("rel_hsync", 32'(video_hsync), 1);
        check("rel_den", 32'(video_den), 0);
        check("rel_frame_start", 32'(video_frame_start), 1);
      end
      if (video_den && first_den == 0) begin
        first_den = cyc;
        check("first_den_h", 32'(timing_h_pos), 4);
        check("first_den_v", 32'(timing_v_pos), 2);
      end
      if (cyc >= 25 && cyc <= 28) check("pixel_x", 32'(pixel_x), 32'(cyc - 25));
      if (cyc == 25) check("pixel_y_row0", 32'(pixel_y), 0);
      if (cyc == 35) check("pixel_y_row1", 32'(pixel_y), 1);
      if (cyc <= 60) begin
        n_den += int'(video_den);
        n_ls  += int'(video_line_start);
        n_hs  += int'(video_hsync);
        n_vs  += int'(video_vsync);
        n_fs  += int'(video_frame_start);
      end
    end
    check("first_den_cyc", 32'(first_den), 25);
    check("den_per_frame", 32'(n_den), 12);
    check("line_start_per_frame", 32'(n_ls), 3);
    check("hsync_per_frame", 32'(n_hs), 12);
    check("vsync_per_frame", 32'(n_vs), 10);
    check("frame_start_per_frame", 32'(n_fs), 1);
    check("frame_start_61", 32'(video_frame_start), 1);
    check("frame_count_61", 32'(frame_count), 1);

    // Illegal request: 2+2+8 > 10.
    set_cfg(10, 8); cfg_valid = 1'b1;
    tick();
    check("illegal_err", 32'(cfg_err), 1);
    check("illegal_pending", 32'(cfg_pending), 0);
    cfg_valid = 1'b0;
    tick();
    check("illegal_err_pulse", 32'(cfg_err), 0);
    check("illegal_h_pos", 32'(timing_h_pos), 2);
    while (cyc < 71) tick();
    check("illegal_line10_h", 32'(timing_h_pos), 0);
    check("illegal_line10_v", 32'(timing_v_pos), 1);

    // Two legal requests (latest wins), then an illegal one while pending.
    set_cfg(11, 4); cfg_valid = 1'b1;
    tick();
    check("legal_pending", 32'(cfg_pending), 1);
    set_cfg(12, 4);
    tick();
    set_cfg(10, 8);
    tick();
    check("pending_err", 32'(cfg_err), 1);
    check("pending_kept", 32'(cfg_pending), 1);
    cfg_valid = 1'b0;
    wait_ack("ack_cycle", 120);
    check("ack_h_pos", 32'(timing_h_pos), 9);
    check("ack_v_pos", 32'(timing_v_pos), 5);
    check("ack_pending_clr", 32'(cfg_pending), 0);
    while (cyc < 132) tick();
    check("line12_h11", 32'(timing_h_pos), 11);
    check("line12_v0", 32'(timing_v_pos), 0);
    tick();
    check("line12_wrap_h", 32'(timing_h_pos), 0);
    check("line12_wrap_v", 32'(timing_v_pos), 1);

    // Back to 10; a second request lands exactly on the commit cycle.
    while (cyc < 140) tick();
    set_cfg(10, 4); cfg_valid = 1'b1;
    tick();
    check("restore_pending", 32'(cfg_pending), 1);
    cfg_valid = 1'b0;
    while (cyc < 191) tick();
    cfg_valid = 1'b1;
    tick();
    check("commit_cycle_ack", 32'(cfg_ack), 1);
    check("commit_cycle_pending", 32'(cfg_pending), 1);
    cfg_valid = 1'b0;
    while (cyc < 203) tick();
    check("line10_again_h", 32'(timing_h_pos), 0);
    check("line10_again_v", 32'(timing_v_pos), 1);
    wait_ack("second_ack_cycle", 252);
    check("second_ack_pending", 32'(cfg_pending), 0);

    // Hold with enable low at h 5 of a visible row.
    while (cyc < 277) tick();
    check("pre_hold_den", 32'(video_den), 1);
    check("pre_hold_h", 32'(timing_h_pos), 4);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_h", 32'(timing_h_pos), 5);
      check("hold_v", 32'(timing_v_pos), 2);
      check("hold_den", 32'(video_den), 0);
    end
    enable = 1'b1;
    tick();
    check("resume_h5", 32'(timing_h_pos), 5);
    check("resume_den", 32'(video_den), 1);
    tick();
    check("resume_h6", 32'(timing_h_pos), 6);
    check("resume_pixel_x", 32'(pixel_x), 2);
    check("resume_frame_count", 32'(frame_count), 4);

    // Reset mid-line.
    reset_n = 1'b0;
    tick();
    check("midrst_h", 32'(timing_h_pos), 0);
    check("midrst_v", 32'(timing_v_pos), 0);
    check("midrst_den", 32'(video_den), 0);
    check("midrst_hsync", 32'(video_hsync), 0);
    check("midrst_frame_count", 32'(frame_count), 0);
    reset_n = 1'b1;
    tick();
    check("midrst_rel_hsync", 32'(video_hsync), 1);
    check("midrst_rel_fs", 32'(video_frame_start), 1);

    // Genlock edge: preload 3/1 when built in, plain counting otherwise.
    ext_sync = 1'b1;
    while (cyc < 291) tick();
`ifdef VIDEO_TIMING_ENGINE_GENLOCK_EN
    check("genlock_h", 32'(timing_h_pos), 4);
    check("genlock_v", 32'(timing_v_pos), 1);
`else
    check("no_genlock_h", 32'(timing_h_pos), 5);
    check("no_genlock_v", 32'(timing_v_pos), 0);
`endif
    ext_sync = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_timing_engine.md
VIDEO_TIMING_ENGINE -- requirements
Module: video_timing_engine

Interface
REQ-001 SHALL have parameter CNT_W, default 14: width of all position/config counters.
REQ-002 SHALL have parameters DEF_H_TOTAL 2200, DEF_H_SYNC 44, DEF_H_BP 148, DEF_H_ACTIVE 1920, DEF_HSYNC_POL 1: reset-time horizontal timing.
REQ-003 SHALL have parameters DEF_V_TOTAL 1125, DEF_V_SYNC 5, DEF_V_BP 36, DEF_V_ACTIVE 1080, DEF_VSYNC_POL 1: reset-time vertical timing.
REQ-004 SHALL have parameters SYNC_H_POS 1079, SYNC_V_POS 132: counter preload on genlock edge.
REQ-005 SHALL have port pixel_clock  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_active, cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_active  in  CNT_W each  requested timing.
REQ-008 SHALL have ports cfg_hsync_pol, cfg_vsync_pol  in  1  requested polarities (1 = active-high).
REQ-009 SHALL have ports cfg_valid in 1 (request strobe), cfg_ack out 1 (commit pulse), cfg_err out 1 (reject pulse), cfg_pending out 1 (request awaiting commit).
REQ-010 SHALL have ports enable in 1 (run/hold) and ext_sync in 1 (asynchronous genlock input).
REQ-011 SHALL have outputs timing_h_pos, timing_v_pos, pixel_x, pixel_y  CNT_W; video_hsync, video_vsync, video_den, video_line_start, video_frame_start  1; frame_count  16.

Function
REQ-012 SHALL count h_pos 0..h_total-1; at wrap h_pos->0 and v_pos increments, v_pos wrapping 0 after v_total-1.
REQ-013 SHALL derive outputs from the counters and register them: every output lags its counter state by exactly 1 cycle.
REQ-014 SHALL assert hsync region for h_pos < h_sync, hvisible for h_sync+h_bp <= h_pos < h_sync+h_bp+h_active; vertical analogous; output sync = region XOR NOT pol.
REQ-015 SHALL drive video_den = hvisible AND vvisible; pixel_x = h_pos-(h_sync+h_bp) when den else 0; pixel_y = v_pos-(v_sync+v_bp) when vvisible else 0.
REQ-016 SHALL pulse video_line_start when h_pos==0 AND vvisible; video_frame_start when h_pos==0 AND v_pos==0.
REQ-017 SHALL increment frame_count (mod 2^16) on each v_pos wrap to 0.
REQ-018 SHALL, on cfg_valid, check h_sync+h_bp+h_active <= h_total, same vertically, h_total>=2, v_total>=2, all sync/active >=1; fail -> 1-cycle cfg_err, active config unchanged, pending unchanged.
REQ-019 SHALL latch a legal request into a shadow set and raise cfg_pending; a later legal cfg_valid while pending overwrites the shadow (latest wins).
REQ-020 SHALL commit shadow to active on the cycle h_pos==h_total-1 AND v_pos==v_total-1 (frame wrap), pulsing cfg_ack and clearing cfg_pending same cycle; new timing applies from next frame's h_pos 0.
REQ-021 SHALL, with cfg_valid on the commit cycle, commit the old shadow and leave the new request pending.
REQ-022 SHALL, when enable=0, hold counters and frame_count, force video_den, line_start, frame_start to 0, syncs to inactive; commits deferred; resume from held position.

Reset
REQ-023 SHALL, on reset_n=0 at a clock edge: counters 0, active config = DEF_* values, shadow cleared, cfg_pending/ack/err 0, frame_count 0, ext_sync synchroniser 0.
REQ-024 SHALL hold all registered outputs at reset: den/line_start/frame_start 0, pixel_x/y 0, positions 0, syncs at inactive level of default polarity.

Configuration
REQ-025 SHALL support macro VIDEO_TIMING_ENGINE_GENLOCK_EN; defined: ext_sync passes a 2-flop synchroniser, rising edge preloads h_pos=SYNC_H_POS, v_pos=SYNC_V_POS (each forced to 0 if >= active total).
REQ-026 SHALL give genlock preload priority over counting, and defer any commit coinciding with it by one frame.
REQ-027 SHALL, without the macro, ignore ext_sync entirely (port kept, no synchroniser flops).

Structure
REQ-028 SHALL place the timing-set struct (totals, sync, bp, active, pol) and the legality-check function in shared package video_timing_pkg.
REQ-029 SHALL instantiate sub-module video_timing_axis twice (h, v): counter, wrap flag, sync/visible region decode for one axis.

Verification (timing h 10/2/2/4, v 6/1/1/3, pol 1 unless noted)
REQ-030 SHALL check reset release: 1 cycle later hsync=1, den=0; den first 1 at h_pos 4 of v_pos 2, pixel_x 0..3, frame_start every 60 cycles.
REQ-031 SHALL check cfg h_total 12 mid-frame: cfg_pending=1, cfg_ack on cycle h 9/v 5, next line 12 cycles long.
REQ-032 SHALL check illegal cfg h_active 8 with h_total 10: cfg_err pulse, pending unchanged, line length stays 10.
REQ-033 SHALL check genlock (macro on, SYNC 3/1): ext_sync rise -> 3 cycles later timing_h_pos=4, timing_v_pos=1; macro off: no change.
REQ-034 SHALL check enable low for 5 cycles at h 5: positions frozen, den 0, resumes at h 6; reset_n low mid-line restores defaults next cycle.
